// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift op encodings shared by the shifter stage and its core
package shifter_pkg;

    localparam int SHIFT_W = 2;

    typedef enum logic [SHIFT_W-1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shifter_core.sv
// rtl/shifter_core.sv - combinational single-position shifter between Rm and the ALU B-mux
module shifter_core
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   in,
    input  logic [SHIFT_W-1:0] shift,
    output logic [WIDTH-1:0]   out,
    output logic               carry
);

    always_comb begin
        out   = in;
        carry = 1'b0;
        case (shift_op_t'(shift))
            SH_NONE: begin
                out   = in;
                carry = 1'b0;
            end
            SH_LSL: begin
                out   = {in[WIDTH-2:0], 1'b0};
                carry = in[WIDTH-1];
            end
            SH_LSR: begin
                out   = {1'b0, in[WIDTH-1:1]};
                carry = in[0];
            end
            SH_ASR: begin
                // Sign bit is replicated so a negative operand stays negative.
                out   = {in[WIDTH-1], in[WIDTH-1:1]};
                carry = in[0];
            end
            default: begin
                out   = in;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - execute-stage shifter with combinational result and valid-qualified register copy
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   out,
    output logic               carry,
    output logic [WIDTH-1:0]   out_q,
    output logic               carry_q,
    output logic               out_valid
);

    logic [WIDTH-1:0] res_d, res_q;
    logic             cry_d, cry_q;
    logic             vld_d, vld_q;

    shifter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in    (in),
        .shift (shift),
        .out   (out),
        .carry (carry)
    );

    // Result and carry only load on valid; valid itself is re-sampled every edge.
    always_comb begin
        res_d = res_q;
        cry_d = cry_q;
        vld_d = in_valid;
        if (in_valid) begin
            res_d = out;
            cry_d = carry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
            cry_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            cry_q <= cry_d;
            vld_q <= vld_d;
        end
    end

    assign out_q     = res_q;
    assign carry_q   = cry_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_shifter_stage.sv
// tb/tb_shifter_stage.sv - directed self-checking bench for shifter_stage
module tb_shifter_stage;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [1:0]  shift;
    logic        in_valid;
    logic [15:0] out;
    logic        carry;
    logic [15:0] out_q;
    logic        carry_q;
    logic        out_valid;

    int n_cmp;
    int n_bad;

    shifter_stage #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .shift     (shift),
        .in_valid  (in_valid),
        .out       (out),
        .carry     (carry),
        .out_q     (out_q),
        .carry_q   (carry_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] vin;
        logic [1:0]  vsh;
        logic [15:0] vout;
        logic        vcry;
    } vec_t;

    vec_t vecs[16];

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        in       = 16'h0000;
        shift    = 2'b00;
        in_valid = 1'b0;

        vecs[0]  = '{16'hF0CF, 2'b00, 16'hF0CF, 1'b0};
        vecs[1]  = '{16'hF0CF, 2'b01, 16'hE19E, 1'b1};
        vecs[2]  = '{16'hF0CF, 2'b10, 16'h7867, 1'b1};
        vecs[3]  = '{16'hF0CF, 2'b11, 16'hF867, 1'b1};
        vecs[4]  = '{16'h8000, 2'b10, 16'h4000, 1'b0};
        vecs[5]  = '{16'h8000, 2'b11, 16'hC000, 1'b0};
        vecs[6]  = '{16'h8000, 2'b01, 16'h0000, 1'b1};
        vecs[7]  = '{16'h0001, 2'b01, 16'h0002, 1'b0};
        vecs[8]  = '{16'h0001, 2'b10, 16'h0000, 1'b1};
        vecs[9]  = '{16'h0001, 2'b11, 16'h0000, 1'b1};
        vecs[10] = '{16'hFFFF, 2'b11, 16'hFFFF, 1'b1};
        vecs[11] = '{16'hFFFF, 2'b10, 16'h7FFF, 1'b1};
        vecs[12] = '{16'h1234, 2'b01, 16'h2468, 1'b0};
        vecs[13] = '{16'h8001, 2'b11, 16'hC000, 1'b1};
        vecs[14] = '{16'h0003, 2'b10, 16'h0001, 1'b1};
        vecs[15] = '{16'hFFFF, 2'b00, 16'hFFFF, 1'b0};

        #2;
        chk("rst_out_q", 32'(out_q), 32'h0);
        chk("rst_carry_q", 32'(carry_q), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);

        // Combinational path works with reset still asserted.
        for (int i = 0; i < 16; i++) begin
            in    = vecs[i].vin;
            shift = vecs[i].vsh;
            #1;
            chk($sformatf("comb_out_%0d", i), 32'(out), 32'(vecs[i].vout));
            chk($sformatf("comb_carry_%0d", i), 32'(carry), 32'(vecs[i].vcry));
        end
        chk("rst_hold_out_q", 32'(out_q), 32'h0);

        @(negedge clk);
        rst = 1'b1;

        in = 16'h1234; shift = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("reg_out_q", 32'(out_q), 32'h2468);
        chk("reg_carry_q", 32'(carry_q), 32'h0);
        chk("reg_out_valid", 32'(out_valid), 32'h1);

        in = 16'hFFFF; shift = 2'b01; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(out_valid), 32'h0);
        chk("hold_out_q", 32'(out_q), 32'h2468);
        chk("hold_carry_q", 32'(carry_q), 32'h0);

        in = 16'h0003; shift = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b0_out_q", 32'(out_q), 32'h0001);
        chk("b2b0_carry_q", 32'(carry_q), 32'h1);
        chk("b2b0_out_valid", 32'(out_valid), 32'h1);

        in = 16'h8001; shift = 2'b11; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b1_out_q", 32'(out_q), 32'hC000);
        chk("b2b1_carry_q", 32'(carry_q), 32'h1);
        chk("b2b1_out_valid", 32'(out_valid), 32'h1);

        // Async reset between edges while a result is valid.
        in = 16'hF0CF; shift = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_out_q", 32'(out_q), 32'h7867);
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_q", 32'(out_q), 32'h0);
        chk("arst_carry_q", 32'(carry_q), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        in = 16'h0001; shift = 2'b01;
        #1;
        chk("arst_comb_out", 32'(out), 32'h0002);
        chk("arst_comb_carry", 32'(carry), 32'h0);
        @(posedge clk); #1;
        chk("arst_held_out_q", 32'(out_q), 32'h0);
        chk("arst_held_out_valid", 32'(out_valid), 32'h0);

        // Release between edges; first valid result appears one edge later.
        #2;
        rst = 1'b1;
        in = 16'h8000; shift = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_q", 32'(out_q), 32'h0000);
        chk("post_rst_carry_q", 32'(carry_q), 32'h1);
        chk("post_rst_out_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_drop_valid", 32'(out_valid), 32'h0);
        chk("post_rst_hold_carry", 32'(carry_q), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
